// File: rtl/his_peak_finder_if.sv
// Bundles the peak finder's RAM read/clear ports and result stream.
// The master modport is the peak finder; the slave modport is the RAM/consumer side.
interface his_peak_finder_if #(
  parameter int NB       = 4,
  parameter int RAM_ADDR = 6,
  parameter int PEAK_MAX = 8,
  parameter int PIX_W    = 2
);
  logic                start;
  logic [PEAK_MAX-1:0] counts;
  logic [RAM_ADDR-1:0] raddr;
  logic                rEnable;
  logic                readFlag;
  logic [RAM_ADDR-1:0] waddr;
  logic                wEnable;
  logic                writeFlag;
  logic [PEAK_MAX-1:0] wdata;
  logic                peak_valid;
  logic [PIX_W-1:0]    peak_pixel;
  logic [NB-1:0]       peak_bin;
  logic [PEAK_MAX-1:0] peak_count;
  logic                busy;
  logic                done;

  modport master (
    input  start, counts,
    output raddr, rEnable, readFlag, waddr, wEnable, writeFlag, wdata,
           peak_valid, peak_pixel, peak_bin, peak_count, busy, done
  );

  modport slave (
    output start, counts,
    input  raddr, rEnable, readFlag, waddr, wEnable, writeFlag, wdata,
           peak_valid, peak_pixel, peak_bin, peak_count, busy, done
  );
endinterface

// File: rtl/his_peak_finder.sv
// Scans every pixel histogram in the shared RAM, reports the arg-max bin per pixel
// and optionally zeroes each bin one cycle after reading it.
module his_peak_finder #(
  parameter int NB                = 4,
  parameter int BIN_NUM_PER_HIS   = 16,
  parameter int PIXEL_NUM_PER_RAM = 4,
  parameter int RAM_ADDR          = 6,
  parameter int PEAK_MAX          = 8,
  parameter bit CLEAR_EN          = 1'b1
) (
  input logic               clk,
  input logic               res,
  his_peak_finder_if.master bus
);
  localparam int PIX_W = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
  localparam logic [NB-1:0]    LAST_BIN = NB'(BIN_NUM_PER_HIS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM_PER_RAM - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EMIT, FIN} state_e;

  state_e              state_q, state_d;
  logic [NB-1:0]       bin_q, bin_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [RAM_ADDR-1:0] raddr_q, raddr_d;
  logic                ren_q, ren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Tag travelling with each read so returning data knows its bin and pixel.
  logic                vld_q;
  logic [NB-1:0]       tag_bin_q;
  logic [PIX_W-1:0]    tag_pix_q;

  logic [PEAK_MAX-1:0] max_q, max_d;
  logic [NB-1:0]       maxbin_q, maxbin_d;
  logic                wen_q;
  logic [RAM_ADDR-1:0] waddr_q;
  logic                pv_q, pv_d;
  logic [PIX_W-1:0]    ppix_q;
  logic [NB-1:0]       pbin_q;
  logic [PEAK_MAX-1:0] pcnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    pix_d   = pix_q;
    raddr_d = '0;
    ren_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          bin_d   = '0;
          pix_d   = '0;
          ren_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (bin_q == LAST_BIN && pix_q == LAST_PIX) begin
          state_d = DRAIN;
        end else begin
          ren_d   = 1'b1;
          raddr_d = raddr_q + RAM_ADDR'(1);
          if (bin_q == LAST_BIN) begin
            bin_d = '0;
            pix_d = pix_q + PIX_W'(1);
          end else begin
            bin_d = bin_q + NB'(1);
          end
        end
      end
      DRAIN: state_d = EMIT;
      EMIT: begin
        state_d = FIN;
        done_d  = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bin 0 reloads the running max; later bins replace it only when strictly larger,
  // so ties keep the lowest bin.
  always_comb begin
    max_d    = max_q;
    maxbin_d = maxbin_q;
    if (vld_q) begin
      if (tag_bin_q == '0) begin
        max_d    = bus.counts;
        maxbin_d = '0;
      end else if (bus.counts > max_q) begin
        max_d    = bus.counts;
        maxbin_d = tag_bin_q;
      end
    end
  end

  assign pv_d = vld_q && (tag_bin_q == LAST_BIN);

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      pix_q     <= '0;
      raddr_q   <= '0;
      ren_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      tag_bin_q <= '0;
      tag_pix_q <= '0;
      max_q     <= '0;
      maxbin_q  <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      pv_q      <= 1'b0;
      ppix_q    <= '0;
      pbin_q    <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      pix_q     <= pix_d;
      raddr_q   <= raddr_d;
      ren_q     <= ren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= ren_q;
      tag_bin_q <= bin_q;
      tag_pix_q <= pix_q;
      max_q     <= max_d;
      maxbin_q  <= maxbin_d;
      // The clear write lands in the data-return cycle, one cycle behind its read.
      wen_q     <= ren_q & CLEAR_EN;
      waddr_q   <= (ren_q & CLEAR_EN) ? raddr_q : '0;
      pv_q      <= pv_d;
      if (pv_d) begin
        ppix_q <= tag_pix_q;
        pbin_q <= maxbin_d;
        pcnt_q <= max_d;
      end
    end
  end

  assign bus.raddr      = raddr_q;
  assign bus.rEnable    = ren_q;
  assign bus.readFlag   = ren_q;
  assign bus.waddr      = waddr_q;
  assign bus.wEnable    = wen_q;
  assign bus.writeFlag  = wen_q;
  assign bus.wdata      = '0;
  assign bus.peak_valid = pv_q;
  assign bus.peak_pixel = ppix_q;
  assign bus.peak_bin   = pbin_q;
  assign bus.peak_count = pcnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_his_peak_finder.sv
// Drives three peak finder instances (small/clear, small/no-clear, default) against
// behavioural RAMs and a per-scan cycle schedule derived from the histogram contents.
module tb_his_peak_finder;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res_s, res_n, res_f;
  logic [2:0] ld;
  int         sel;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] img   [64];
  int         mdl   [3][64];
  logic [7:0] ram_s [64];
  logic [7:0] ram_n [64];
  logic [7:0] ram_f [64];

  his_peak_finder_if #(.NB(4), .RAM_ADDR(AW), .PEAK_MAX(8), .PIX_W(1)) if_s ();
  his_peak_finder_if #(.NB(4), .RAM_ADDR(AW), .PEAK_MAX(8), .PIX_W(1)) if_n ();
  his_peak_finder_if #(.NB(4), .RAM_ADDR(AW), .PEAK_MAX(8), .PIX_W(2)) if_f ();

  his_peak_finder #(.NB(4), .BIN_NUM_PER_HIS(4), .PIXEL_NUM_PER_RAM(2), .RAM_ADDR(AW),
                    .PEAK_MAX(8), .CLEAR_EN(1'b1)) u_s (.clk(clk), .res(res_s), .bus(if_s));
  his_peak_finder #(.NB(4), .BIN_NUM_PER_HIS(4), .PIXEL_NUM_PER_RAM(2), .RAM_ADDR(AW),
                    .PEAK_MAX(8), .CLEAR_EN(1'b0)) u_n (.clk(clk), .res(res_n), .bus(if_n));
  his_peak_finder u_f (.clk(clk), .res(res_f), .bus(if_f));

  // Behavioural RAMs: registered read, write port honoured whenever wEnable is high.
  always @(posedge clk) begin
    if (ld[0]) begin
      for (int i = 0; i < 64; i++) ram_s[i] <= img[i];
    end else if (if_s.wEnable) ram_s[if_s.waddr] <= if_s.wdata;
    if (if_s.rEnable) if_s.counts <= ram_s[if_s.raddr];
  end
  always @(posedge clk) begin
    if (ld[1]) begin
      for (int i = 0; i < 64; i++) ram_n[i] <= img[i];
    end else if (if_n.wEnable) ram_n[if_n.waddr] <= if_n.wdata;
    if (if_n.rEnable) if_n.counts <= ram_n[if_n.raddr];
  end
  always @(posedge clk) begin
    if (ld[2]) begin
      for (int i = 0; i < 64; i++) ram_f[i] <= img[i];
    end else if (if_f.wEnable) ram_f[if_f.waddr] <= if_f.wdata;
    if (if_f.rEnable) if_f.counts <= ram_f[if_f.raddr];
  end

  typedef struct packed {
    logic [31:0] raddr, waddr, wdata, ppix, pbin, pcnt;
    logic        ren, rflag, wen, wflag, pv, busy, done;
  } obs_t;
  obs_t obs;

  always_comb begin
    obs = '0;
    case (sel)
      0: obs = '{32'(if_s.raddr), 32'(if_s.waddr), 32'(if_s.wdata), 32'(if_s.peak_pixel),
                 32'(if_s.peak_bin), 32'(if_s.peak_count), if_s.rEnable, if_s.readFlag,
                 if_s.wEnable, if_s.writeFlag, if_s.peak_valid, if_s.busy, if_s.done};
      1: obs = '{32'(if_n.raddr), 32'(if_n.waddr), 32'(if_n.wdata), 32'(if_n.peak_pixel),
                 32'(if_n.peak_bin), 32'(if_n.peak_count), if_n.rEnable, if_n.readFlag,
                 if_n.wEnable, if_n.writeFlag, if_n.peak_valid, if_n.busy, if_n.done};
      default: obs = '{32'(if_f.raddr), 32'(if_f.waddr), 32'(if_f.wdata), 32'(if_f.peak_pixel),
                 32'(if_f.peak_bin), 32'(if_f.peak_count), if_f.rEnable, if_f.readFlag,
                 if_f.wEnable, if_f.writeFlag, if_f.peak_valid, if_f.busy, if_f.done};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic rs);
    case (w)
      0:       begin if_s.start = st; res_s = rs; end
      1:       begin if_n.start = st; res_n = rs; end
      default: begin if_f.start = st; res_f = rs; end
    endcase
  endtask

  function automatic logic [31:0] ram_rd(input int w, input int a);
    case (w)
      0:       return 32'(ram_s[a]);
      1:       return 32'(ram_n[a]);
      default: return 32'(ram_f[a]);
    endcase
  endfunction

  task automatic load(input int w);
    for (int i = 0; i < 64; i++) mdl[w][i] = int'(img[i]);
    @(negedge clk); ld[w] = 1'b1;
    @(negedge clk); ld[w] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " raddr"}, obs.raddr, 0);
    check({tag, " waddr"}, obs.waddr, 0);
    check({tag, " wdata"}, obs.wdata, 0);
    check({tag, " pixel"}, obs.ppix, 0);
    check({tag, " bin"},   obs.pbin, 0);
    check({tag, " count"}, obs.pcnt, 0);
    check({tag, " ctrl"},  32'({obs.ren, obs.rflag, obs.wen, obs.wflag, obs.pv, obs.busy, obs.done}), 0);
  endtask

  task automatic check_ram(input int w, input int n);
    for (int i = 0; i < n; i++) check($sformatf("ram%0d[%0d]", w, i), ram_rd(w, i), 32'(mdl[w][i]));
  endtask

  // One scan with start in cycle 0; outputs are checked mid-cycle against the schedule
  // implied by the histogram contents. restart_at/reset_at inject start/res in that cycle.
  task automatic scan(input int w, input int nb, input int np, input bit clr,
                      input int restart_at, input int reset_at);
    int n = nb * np;
    int last = (reset_at > 0) ? reset_at + 3 : n + 5;
    int exp_bin [4];
    int exp_cnt [4];
    for (int p = 0; p < np; p++) begin
      exp_cnt[p] = -1;
      exp_bin[p] = 0;
      for (int b = 0; b < nb; b++)
        if (mdl[w][p*nb+b] > exp_cnt[p]) begin
          exp_cnt[p] = mdl[w][p*nb+b];
          exp_bin[p] = b;
        end
    end
    sel = w;
    @(negedge clk); drive(w, 1'b1, 1'b0);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (reset_at > 0 && c > reset_at) begin
        if (c == reset_at + 1) check_zero($sformatf("rst c%0d", c));
        else check($sformatf("idle c%0d", c), 32'({obs.ren, obs.wen, obs.pv, obs.busy, obs.done}), 0);
      end else begin
        bit rd = (c <= n);
        bit wr = clr && (c >= 2) && (c <= n + 1);
        int pe = -1;
        check($sformatf("c%0d rEnable", c), 32'(obs.ren), 32'(rd));
        check($sformatf("c%0d readFlag", c), 32'(obs.rflag), 32'(rd));
        if (rd) check($sformatf("c%0d raddr", c), obs.raddr, 32'(c - 1));
        check($sformatf("c%0d wEnable", c), 32'(obs.wen), 32'(wr));
        check($sformatf("c%0d writeFlag", c), 32'(obs.wflag), 32'(wr));
        if (wr) check($sformatf("c%0d waddr", c), obs.waddr, 32'(c - 2));
        check($sformatf("c%0d wdata", c), obs.wdata, 0);
        for (int p = 0; p < np; p++) if (c == 2 + (p + 1) * nb) pe = p;
        check($sformatf("c%0d peak_valid", c), 32'(obs.pv), 32'(pe >= 0));
        if (pe >= 0) begin
          check($sformatf("c%0d peak_pixel", c), obs.ppix, 32'(pe));
          check($sformatf("c%0d peak_bin", c), obs.pbin, 32'(exp_bin[pe]));
          check($sformatf("c%0d peak_count", c), obs.pcnt, 32'(exp_cnt[pe]));
        end
        check($sformatf("c%0d busy", c), 32'(obs.busy), 32'(c <= n + 3));
        check($sformatf("c%0d done", c), 32'(obs.done), 32'(c == n + 3));
      end
      drive(w, c == restart_at, c == reset_at);
    end
    drive(w, 1'b0, 1'b0);
    if (clr) begin
      int cleared = (reset_at > 0) ? reset_at - 1 : n;
      for (int a = 0; a < cleared && a < n; a++) mdl[w][a] = 0;
    end
  endtask

  initial begin
    ld = '0; sel = 0;
    if_s.start = 1'b0; if_n.start = 1'b0; if_f.start = 1'b0;
    res_s = 1'b1; res_n = 1'b1; res_f = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      sel = w; #1;
      check_zero($sformatf("por%0d", w));
    end
    @(negedge clk); res_s = 1'b0; res_n = 1'b0; res_f = 1'b0;

    // Tie in pixel 0 and a late peak in pixel 1, with clearing.
    img = '{default: 8'd0};
    img[0] = 8'd3; img[1] = 8'd9; img[2] = 8'd2; img[3] = 8'd9; img[7] = 8'd7;
    load(0);
    scan(0, 4, 2, 1'b1, 0, 0);
    check_ram(0, 8);
    // Second scan of the now-cleared RAM reports bin 0, count 0.
    scan(0, 4, 2, 1'b1, 0, 0);

    // Restart mid-scan is ignored.
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    load(0);
    scan(0, 4, 2, 1'b1, 5, 0);
    check_ram(0, 8);

    // Reset in cycle 4 aborts, leaving the first bins cleared; a clean scan follows.
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(1, 255));
    load(0);
    scan(0, 4, 2, 1'b1, 0, 4);
    check_ram(0, 8);
    scan(0, 4, 2, 1'b1, 0, 0);
    check_ram(0, 8);

    // Narrow value range forces ties; start in the done cycle is ignored.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 3));
      load(0);
      scan(0, 4, 2, 1'b1, 11, 0);
      check_ram(0, 8);
    end

    // Read-only variant: no writes and RAM untouched.
    img = '{default: 8'd0};
    img[0] = 8'd3; img[1] = 8'd9; img[2] = 8'd2; img[3] = 8'd9; img[7] = 8'd7;
    load(1);
    scan(1, 4, 2, 1'b0, 0, 0);
    check_ram(1, 8);
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    load(1);
    scan(1, 4, 2, 1'b0, 0, 0);
    check_ram(1, 8);

    // Default parameters: full-scale count in bin 15 of every pixel.
    for (int i = 0; i < 64; i++) img[i] = (i % 16 == 15) ? 8'd255 : 8'($urandom_range(0, 254));
    load(2);
    scan(2, 16, 4, 1'b1, 0, 0);
    check_ram(2, 64);
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    load(2);
    scan(2, 16, 4, 1'b1, 0, 0);
    check_ram(2, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
